// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache controller:
// address geometry, FSM state encoding and address-field helpers.
package cache_pkg;

    localparam int ADDR_W = 10;
    localparam int TAG_W  = 5;
    localparam int IDX_W  = 1;
    localparam int OFF_W  = 2;
    localparam int BLK_W  = TAG_W + IDX_W;
    localparam int LINE_W = 128;
    localparam int WAYS   = 2;
    localparam int SETS   = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        REFILL,
        UPDATE,
        WTHRU,
        RESP
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W+2 +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[2 +: OFF_W];
    endfunction

    function automatic logic [BLK_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: BLK_W];
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag, valid and LRU state for the 2-way cache: per-way hit compare on the
// lookup address, victim choice, and update ports for LRU touch and line fill.
module cache_tag_store
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] look_idx,
    input  logic [TAG_W-1:0] look_tag,
    output logic             hit,
    output logic             hit_way,
    output logic             victim_way,
    input  logic             touch_en,
    input  logic             touch_way,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             fill_way,
    input  logic [TAG_W-1:0] fill_tag
);

    // Entries are flattened as {set, way}.
    logic [TAG_W-1:0]     tag_reg [SETS*WAYS];
    logic [SETS*WAYS-1:0] valid_reg;
    logic [SETS-1:0]      lru_reg;
    logic [WAYS-1:0]      way_match;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
            localparam logic WAY = 1'(gi);
            assign way_match[gi] = valid_reg[{look_idx, WAY}] &&
                                   (tag_reg[{look_idx, WAY}] == look_tag);
        end
    endgenerate

    assign hit        = |way_match;
    // Way 0 takes priority if both ways ever match.
    assign hit_way    = ~way_match[0] & way_match[1];
    assign victim_way = !valid_reg[{look_idx, 1'b0}] ? 1'b0 :
                        !valid_reg[{look_idx, 1'b1}] ? 1'b1 :
                        lru_reg[look_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            lru_reg   <= '0;
            for (int i = 0; i < SETS*WAYS; i++) begin
                tag_reg[i] <= '0;
            end
        end else if (fill_en) begin
            valid_reg[{fill_idx, fill_way}] <= 1'b1;
            tag_reg[{fill_idx, fill_way}]   <= fill_tag;
            lru_reg[fill_idx]               <= ~fill_way;
        end else if (touch_en) begin
            lru_reg[look_idx] <= ~touch_way;
        end
    end

endmodule

// File: rtl/cache2w_ctrl.sv
// Control FSM for the 2-way write-through, write-allocate cache. Optional
// saturating performance counters are enabled with CACHE_PERF_CNT_EN.
module cache2w_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic              arr_way,
    output logic [IDX_W-1:0]  arr_idx,
    output logic [OFF_W-1:0]  arr_word,
    output logic              arr_wr_word,
    output logic              arr_fill,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BLK_W-1:0]  mem_blk,
`ifdef CACHE_PERF_CNT_EN
    output logic [15:0]       perf_hits,
    output logic [15:0]       perf_misses,
    output logic [15:0]       perf_wthru,
`endif
    input  logic              mem_ready
);

    state_t           state_reg, state_next;
    logic [BLK_W-1:0] blk_reg;
    logic [OFF_W-1:0] off_reg;
    logic             we_reg;
    logic             way_reg;
    logic             hit_reg;
    logic             hit;
    logic             hit_way;
    logic             victim_way;
    logic             accept;
    logic             is_idle;

    assign is_idle = (state_reg == IDLE);
    assign accept  = is_idle && cpu_req;

    cache_tag_store u_tags (
        .clk        (clk),
        .rst_n      (rst_n),
        .look_idx   (addr_idx(cpu_addr)),
        .look_tag   (addr_tag(cpu_addr)),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .touch_en   (accept && hit),
        .touch_way  (hit_way),
        .fill_en    (arr_fill),
        .fill_idx   (blk_reg[IDX_W-1:0]),
        .fill_way   (way_reg),
        .fill_tag   (blk_reg[IDX_W +: TAG_W])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            blk_reg   <= '0;
            off_reg   <= '0;
            we_reg    <= 1'b0;
            way_reg   <= 1'b0;
            hit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                blk_reg <= addr_blk(cpu_addr);
                off_reg <= addr_off(cpu_addr);
                we_reg  <= cpu_we;
                hit_reg <= hit;
                way_reg <= hit ? hit_way : victim_way;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cpu_done    = 1'b0;
        arr_wr_word = 1'b0;
        arr_fill    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    state_next = !hit ? REFILL : (cpu_we ? UPDATE : RESP);
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    arr_fill   = 1'b1;
                    state_next = we_reg ? UPDATE : RESP;
                end
            end
            UPDATE: begin
                arr_wr_word = 1'b1;
                state_next  = WTHRU;
            end
            WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cpu_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_busy = !is_idle;
    assign cpu_hit  = hit_reg;
    assign mem_blk  = mem_req ? blk_reg : '0;

    // The IDLE path follows cpu_addr directly, so force it low while in reset.
    assign arr_way  = rst_n && (is_idle ? hit_way : way_reg);
    assign arr_idx  = !rst_n ? '0 : (is_idle ? addr_idx(cpu_addr) : blk_reg[IDX_W-1:0]);
    assign arr_word = !rst_n ? '0 : (is_idle ? addr_off(cpu_addr) : off_reg);

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wthru  <= '0;
        end else begin
            if (accept && hit && perf_hits != 16'hFFFF) begin
                perf_hits <= perf_hits + 16'd1;
            end
            if (accept && !hit && perf_misses != 16'hFFFF) begin
                perf_misses <= perf_misses + 16'd1;
            end
            if (state_reg == WTHRU && mem_ready && perf_wthru != 16'hFFFF) begin
                perf_wthru <= perf_wthru + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache2w_ctrl.sv
// Randomized self-checking bench for cache2w_ctrl against a set/way/LRU
// reference model, with a reactive memory responder of selectable latency.
module tb_cache2w_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic       mem_ready = 1'b0;
    logic       cpu_busy, cpu_done, cpu_hit;
    logic       arr_way, arr_idx, arr_wr_word, arr_fill;
    logic [1:0] arr_word;
    logic       mem_req, mem_we;
    logic [5:0] mem_blk;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0] perf_hits, perf_misses, perf_wthru;
`endif

    cache2w_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_busy    (cpu_busy),
        .cpu_done    (cpu_done),
        .cpu_hit     (cpu_hit),
        .arr_way     (arr_way),
        .arr_idx     (arr_idx),
        .arr_word    (arr_word),
        .arr_wr_word (arr_wr_word),
        .arr_fill    (arr_fill),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_blk     (mem_blk),
`ifdef CACHE_PERF_CNT_EN
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses),
        .perf_wthru  (perf_wthru),
`endif
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what each set/way holds and which way goes next.
    bit [4:0] m_tag   [2][2];
    bit       m_valid [2][2];
    bit       m_lru   [2];

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({cpu_busy, cpu_done, cpu_hit, arr_way, arr_idx, arr_word,
                    arr_wr_word, arr_fill, mem_req, mem_we, mem_blk});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        cpu_addr  = 10'h3FC;
        rst_n     = 1'b0;
        #1;
        check("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        check("reset_outputs_hold", all_outputs(), 0);
        rst_n    = 1'b1;
        cpu_addr = '0;
        model_reset();
    endtask

    // One CPU access; memory answers each phase after 'lat' wait cycles.
    task automatic access(input bit we, input logic [9:0] addr, input int lat, input bit hold);
        bit s;
        bit [4:0] t;
        bit exp_hit, exp_way, done;
        int exp_cycles, cyc, fills, wrs, rd_cyc, wr_cyc, fill_at, wr_at, cnt;
        s = addr[4];
        t = addr[9:5];
        exp_hit = 1'b0;
        if (m_valid[s][0] && m_tag[s][0] == t) begin
            exp_hit = 1'b1; exp_way = 1'b0;
        end else if (m_valid[s][1] && m_tag[s][1] == t) begin
            exp_hit = 1'b1; exp_way = 1'b1;
        end else if (!m_valid[s][0]) exp_way = 1'b0;
        else if (!m_valid[s][1]) exp_way = 1'b1;
        else exp_way = m_lru[s];
        exp_cycles = 1 + (exp_hit ? 0 : lat + 1) + (we ? lat + 2 : 0);

        @(negedge clk);
        check("idle_busy", 32'(cpu_busy), 0);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; mem_ready = 1'b0;
        #1;
        check("idle_idx", 32'(arr_idx), 32'(s));
        check("idle_word", 32'(arr_word), 32'(addr[3:2]));
        if (exp_hit) check("idle_way", 32'(arr_way), 32'(exp_way));

        cyc = 0; fills = 0; wrs = 0; rd_cyc = 0; wr_cyc = 0;
        fill_at = -1; wr_at = -1; cnt = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!hold) cpu_req = 1'b0;
            mem_ready = 1'b0;
            if (mem_req) begin
                check("mem_blk", 32'(mem_blk), 32'(addr[9:4]));
                if (mem_we) wr_cyc++; else rd_cyc++;
                if (cnt == lat) begin
                    mem_ready = 1'b1; cnt = 0;
                end else cnt++;
            end
            #1;
            if (arr_fill) begin
                fills++; fill_at = cyc;
                check("fill_way", 32'(arr_way), 32'(exp_way));
                check("fill_idx", 32'(arr_idx), 32'(s));
            end
            if (arr_wr_word) begin
                wrs++; wr_at = cyc;
                check("wr_way", 32'(arr_way), 32'(exp_way));
                check("wr_word", 32'(arr_word), 32'(addr[3:2]));
            end
            if (cpu_done) begin
                done = 1'b1;
                check("cpu_hit", 32'(cpu_hit), 32'(exp_hit));
            end
        end
        mem_ready = 1'b0;
        check("done_seen", 32'(done), 1);
        check("latency", 32'(cyc), 32'(exp_cycles));
        check("fill_count", 32'(fills), exp_hit ? 0 : 1);
        check("wr_count", 32'(wrs), we ? 1 : 0);
        check("mem_rd_cycles", 32'(rd_cyc), exp_hit ? 0 : 32'(lat + 1));
        check("mem_wr_cycles", 32'(wr_cyc), we ? 32'(lat + 1) : 0);
        if (we && !exp_hit) check("fill_before_wr", 32'(fill_at < wr_at), 1);

        if (exp_hit) begin
            m_lru[s] = ~exp_way;
        end else begin
            m_valid[s][exp_way] = 1'b1;
            m_tag[s][exp_way]   = t;
            m_lru[s]            = ~exp_way;
        end
        txn_no++;
        $display("txn %0d %s addr=%03h lat=%0d hit=%0b way=%0d cycles=%0d",
                 txn_no, we ? "WR" : "RD", addr, lat, exp_hit, exp_way, cyc);
    endtask

    initial begin
        model_reset();
        // Outputs during power-on reset, even with a live-looking address.
        cpu_addr = 10'h3FC;
        #1;
        check("por_outputs", all_outputs(), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        cpu_addr = '0;

        // Reset while a refill is outstanding abandons it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
        @(negedge clk);
        cpu_req = 1'b0;
        check("mid_refill_req", 32'(mem_req), 1);
        do_reset();
        access(1'b0, 10'h000, 2, 1'b0);

        // Cold miss then same-line hit.
        do_reset();
        access(1'b0, 10'h000, 3, 1'b0);
        access(1'b0, 10'h004, 1, 1'b0);

        // Write hit, set-0 conflict and eviction.
        access(1'b0, 10'h020, 1, 1'b0);
        access(1'b1, 10'h028, 2, 1'b0);
        access(1'b0, 10'h000, 0, 1'b0);
        access(1'b0, 10'h040, 1, 1'b0);
        access(1'b0, 10'h000, 0, 1'b0);
        access(1'b0, 10'h020, 0, 1'b0);

        // Write miss at the top of the address space, then a held request.
        access(1'b1, 10'h3FC, 2, 1'b0);
        access(1'b0, 10'h1F0, 3, 1'b1);
        access(1'b0, 10'h1F4, 0, 1'b1);

        for (int i = 0; i < 120; i++) begin
            logic [9:0] a;
            a = {3'b000, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) a[9:7] = 3'($urandom);
            access(1'($urandom), a, int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0));
        end

        cpu_req = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
